// File: rtl/master_cpu_ocimem_pkg.sv
// Shared definitions for the OCI memory arbiter: FSM state encoding and
// the bit positions of the JTAG jdo command fields.
package master_cpu_ocimem_pkg;

    localparam int unsigned JDO_W     = 38;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_LSB  = 17;
    localparam int unsigned RD_BIT    = 34;
    localparam int unsigned WDATA_MSB = 34;
    localparam int unsigned WDATA_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_JTAG_ACC,
        ST_JTAG_RDW,
        ST_CPU_ACC,
        ST_CPU_RDW
    } state_t;

endpackage

// File: rtl/master_cpu_ocimem_jtag_cmd.sv
// JTAG command front end: decodes the debug strobes into a single pending
// RAM command, keeps the auto-incrementing JTAG address and the sticky
// overflow flag, and snapshots the command when the arbiter consumes it.
// Ports:
//   take_action_ocimem_a/b, take_no_action_ocimem_a, jdo : JTAG strobes + data
//   consume  : arbiter starts the pending command this cycle
//   step     : in-flight command completes; advance the address
//   jtag_pend, jtag_ovf : pending flag, sticky dropped-strobe flag
//   act_wr, act_addr, act_wdata : snapshot of the command being executed
module master_cpu_ocimem_jtag_cmd
    import master_cpu_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              consume,
    input  logic              step,
    output logic              jtag_pend,
    output logic              jtag_ovf,
    output logic              act_wr,
    output logic [ADDR_W-1:0] act_addr,
    output logic [DATA_W-1:0] act_wdata
);

    logic [ADDR_W-1:0] jtag_addr;
    logic              cmd_wr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              skip_inc;
    logic              accept;
    logic              ld_a;
    logic              ld_b;
    logic              ld_n;
    logic              drop;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:WDATA_MSB+1], jdo[WDATA_LSB-1:0]};

    // A strobe is taken when nothing is pending or the pending command leaves now.
    always_comb begin
        accept = !jtag_pend || consume;
        ld_a   = take_action_ocimem_a && accept;
        ld_b   = take_action_ocimem_b && !take_action_ocimem_a && accept;
        ld_n   = take_no_action_ocimem_a && !take_action_ocimem_a
                 && !take_action_ocimem_b && accept;
        drop   = (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a)
                 && !accept;
    end

    // skip_inc: an address load since the last consume overrides the
    // post-access increment of the command already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr <= '0;
            jtag_pend <= 1'b0;
            jtag_ovf  <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_wdata <= '0;
            skip_inc  <= 1'b0;
            act_wr    <= 1'b0;
            act_addr  <= '0;
            act_wdata <= '0;
        end else begin
            if (ld_a)
                jtag_addr <= jdo[ADDR_LSB +: ADDR_W];
            else if (step && !skip_inc)
                jtag_addr <= jtag_addr + ADDR_W'(1);

            if (ld_a)
                jtag_pend <= jdo[RD_BIT];
            else if (ld_b || ld_n)
                jtag_pend <= 1'b1;
            else if (consume)
                jtag_pend <= 1'b0;

            if (ld_a || ld_n)
                cmd_wr <= 1'b0;
            else if (ld_b)
                cmd_wr <= 1'b1;

            if (ld_b)
                cmd_wdata <= jdo[WDATA_MSB:WDATA_LSB];

            if (ld_a)
                jtag_ovf <= 1'b0;
            else if (drop)
                jtag_ovf <= 1'b1;

            if (ld_a)
                skip_inc <= 1'b1;
            else if (consume)
                skip_inc <= 1'b0;

            if (consume) begin
                act_wr    <= cmd_wr;
                act_addr  <= jtag_addr;
                act_wdata <= cmd_wdata;
            end
        end
    end

endmodule

// File: rtl/master_cpu_ocimem_arbiter.sv
// OCI RAM controller: arbitrates JTAG debug commands against CPU Avalon
// accesses to a 2^ADDR_W x 32 RAM with 1-cycle read latency, alternating
// under contention, and returns JTAG read data on MonDReg.
// Optional build macro MASTER_CPU_OCIMEM_WP_EN: CPU writes below WP_WORDS
// are accepted but suppressed unless debugack is high.
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   take_*_ocimem_*, jdo      : JTAG command strobes and data
//   debugack                  : CPU in debug mode (write-protect bypass)
//   cpu_*                     : Avalon slave interface
//   ram_*                     : RAM port (ram_we/ram_re/ram_addr decoded from state)
//   MonDReg, jtag_busy, jtag_ovf : JTAG read data and status
module master_cpu_ocimem_arbiter
    import master_cpu_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WP_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              debugack,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_ovf
);

    state_t            state;
    logic              last_cpu;
    logic [DATA_W-1:0] mon_dreg;
    logic              cpu_req;
    logic              consume;
    logic              step;
    logic              jtag_pend;
    logic              act_wr;
    logic [ADDR_W-1:0] act_addr;
    logic [DATA_W-1:0] act_wdata;
    logic              wp_block;

    master_cpu_ocimem_jtag_cmd #(.ADDR_W(ADDR_W)) u_jtag_cmd (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .consume                 (consume),
        .step                    (step),
        .jtag_pend               (jtag_pend),
        .jtag_ovf                (jtag_ovf),
        .act_wr                  (act_wr),
        .act_addr                (act_addr),
        .act_wdata               (act_wdata)
    );

`ifdef MASTER_CPU_OCIMEM_WP_EN
    localparam int unsigned AW1 = ADDR_W + 1;
    localparam logic [ADDR_W:0] WP_LIMIT = AW1'(WP_WORDS);
    assign wp_block = ({1'b0, cpu_address} < WP_LIMIT) && !debugack;
`else
    logic unused_wp;
    assign unused_wp = ^{debugack, 32'(WP_WORDS)};
    assign wp_block  = 1'b0;
`endif

    assign cpu_req = cpu_read | cpu_write;
    // JTAG goes first unless the CPU is waiting and JTAG had the last turn.
    assign consume = (state == ST_IDLE) && jtag_pend && (!cpu_req || last_cpu);
    assign step    = ((state == ST_JTAG_ACC) && act_wr) || (state == ST_JTAG_RDW);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            last_cpu <= 1'b1;
            mon_dreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (consume) begin
                        state    <= ST_JTAG_ACC;
                        last_cpu <= 1'b0;
                    end else if (cpu_req) begin
                        state    <= ST_CPU_ACC;
                        last_cpu <= 1'b1;
                    end
                end
                ST_JTAG_ACC: state <= act_wr ? ST_IDLE : ST_JTAG_RDW;
                ST_JTAG_RDW: begin
                    mon_dreg <= ram_rdata;
                    state    <= ST_IDLE;
                end
                ST_CPU_ACC:  state <= (cpu_read && !cpu_write) ? ST_CPU_RDW : ST_IDLE;
                ST_CPU_RDW:  state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

    // RAM and Avalon strobes decode from state so reset kills them at once.
    assign ram_we = ((state == ST_JTAG_ACC) && act_wr)
                  || ((state == ST_CPU_ACC) && cpu_write && !wp_block);
    assign ram_re = ((state == ST_JTAG_ACC) && !act_wr)
                  || ((state == ST_CPU_ACC) && cpu_read && !cpu_write);
    assign ram_addr  = (state == ST_JTAG_ACC) ? act_addr
                     : (state == ST_CPU_ACC)  ? cpu_address : '0;
    assign ram_wdata = (state == ST_JTAG_ACC) ? act_wdata
                     : (state == ST_CPU_ACC)  ? cpu_writedata : '0;

    assign cpu_waitrequest   = (state != ST_CPU_ACC);
    assign cpu_readdatavalid = (state == ST_CPU_RDW);
    assign cpu_readdata      = (state == ST_CPU_RDW) ? ram_rdata : '0;

    assign MonDReg   = mon_dreg;
    assign jtag_busy = jtag_pend || (state == ST_JTAG_ACC) || (state == ST_JTAG_RDW);

endmodule

// File: tb/tb_master_cpu_ocimem_arbiter.sv
// Directed bench for master_cpu_ocimem_arbiter with a behavioural
// 256x32 RAM (1-cycle read latency) and a backdoor preload port.
module tb_master_cpu_ocimem_arbiter;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [37:0]       jdo;
    logic              debugack;
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_writedata;
    logic              cpu_waitrequest;
    logic [31:0]       cpu_readdata;
    logic              cpu_readdatavalid;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;
    logic [31:0]       MonDReg;
    logic              jtag_busy;
    logic              jtag_ovf;

    logic [31:0]       mem [0:255];
    logic              bd_we;
    logic [7:0]        bd_addr;
    logic [31:0]       bd_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    master_cpu_ocimem_arbiter #(.ADDR_W(ADDR_W), .WP_WORDS(64)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .debugack                (debugack),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_address             (cpu_address),
        .cpu_writedata           (cpu_writedata),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_we                  (ram_we),
        .ram_re                  (ram_re),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_ovf                (jtag_ovf)
    );

    always @(posedge clk) begin
        if (bd_we)  mem[bd_addr] <= bd_data;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[34] = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action; returns in cycle T+1
    task automatic strobe(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (jtag_busy && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(jtag_busy), 32'd0);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input string tag,
                          input logic exp_we);
        int n;
        cpu_write = 1'b1; cpu_address = a; cpu_writedata = d;
        n = 0;
        tick();
        while (cpu_waitrequest && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_accept"}, 32'(cpu_waitrequest), 32'd0);
        check({tag, "_we"}, 32'(ram_we), 32'(exp_we));
        tick();
        cpu_write = 1'b0;
    endtask

    initial begin
        logic [3:0] gr;
        int         g, n_acc, n_val, bad_data;
        logic       drop_next;

        reset_n = 1'b0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0; jdo = '0; debugack = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_writedata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #3;
        check("rst_waitreq", 32'(cpu_waitrequest), 32'd1);
        check("rst_ram_we",  32'(ram_we), 32'd0);
        check("rst_ram_re",  32'(ram_re), 32'd0);
        check("rst_rdv",     32'(cpu_readdatavalid), 32'd0);
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_busy",    32'({jtag_busy, jtag_ovf}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        poke(8'h10, 32'hDEADBEEF);
        poke(8'h11, 32'h11111111);
        poke(8'h20, 32'hC0C0C0C0);
        poke(8'h40, 32'h40404040);
        poke(8'h41, 32'h41414141);
        poke(8'h60, 32'h60606060);
        poke(8'h05, 32'h00000000);

        // JTAG read with address load: ram_re at T+2, MonDReg at T+4
        strobe(0, mk_a(8'h10, 1'b1));
        check("rd_busy_t1", 32'(jtag_busy), 32'd1);
        tick();
        check("rd_re_t2",   32'(ram_re), 32'd1);
        check("rd_addr_t2", 32'(ram_addr), 32'h10);
        tick();
        tick();
        check("rd_mondreg_t4", MonDReg, 32'hDEADBEEF);
        wait_idle("rd_idle");
        strobe(2, '0);
        wait_idle("rd2_idle");
        check("rd_postinc", MonDReg, 32'h11111111);

        // Writes wrapping past the top of the address space
        strobe(0, mk_a(8'hFF, 1'b0));
        wait_idle("wr_a_idle");
        strobe(1, mk_b(32'd1));
        tick();
        check("wr_we_t2",    32'(ram_we), 32'd1);
        check("wr_addr_t2",  32'(ram_addr), 32'hFF);
        check("wr_wdata_t2", ram_wdata, 32'd1);
        wait_idle("wr1_idle");
        strobe(1, mk_b(32'd2));
        wait_idle("wr2_idle");
        strobe(1, mk_b(32'd3));
        wait_idle("wr3_idle");
        check("wr_mem_ff", mem[8'hFF], 32'd1);
        check("wr_mem_00", mem[8'h00], 32'd2);
        check("wr_mem_01", mem[8'h01], 32'd3);

        // Strobe dropped while a command is pending behind a CPU access
        strobe(0, mk_a(8'h40, 1'b0));
        wait_idle("ovf_a_idle");
        cpu_read = 1'b1; cpu_address = 8'h22;
        tick();
        check("ovf_cpu_acc", 32'(cpu_waitrequest), 32'd0);
        take_no_action_ocimem_a = 1'b1;
        tick();
        cpu_read = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b1;
        jdo = mk_b(32'h0BAD0BAD);
        tick();
        take_action_ocimem_b = 1'b0;
        check("ovf_set", 32'(jtag_ovf), 32'd1);
        wait_idle("ovf_idle");
        check("ovf_sticky",   32'(jtag_ovf), 32'd1);
        check("ovf_rd_data",  MonDReg, 32'h40404040);
        check("ovf_discard",  mem[8'h41], 32'h41414141);
        strobe(0, mk_a(8'h50, 1'b0));
        check("ovf_clear", 32'(jtag_ovf), 32'd0);
        wait_idle("ovf_clr_idle");

        // Reset in the middle of a JTAG write
        strobe(0, mk_a(8'h60, 1'b0));
        wait_idle("rst_a_idle");
        strobe(1, mk_b(32'h12345678));
        tick();
        check("rstw_we_before", 32'(ram_we), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rstw_we_async", 32'(ram_we), 32'd0);
        check("rstw_addr",     32'(ram_addr), 32'd0);
        check("rstw_waitreq",  32'(cpu_waitrequest), 32'd1);
        check("rstw_mondreg",  MonDReg, 32'd0);
        check("rstw_busy",     32'(jtag_busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rstw_mem", mem[8'h60], 32'h60606060);

        // Contention: CPU read held with back-to-back JTAG reads
        strobe(0, mk_a(8'h30, 1'b1));
        cpu_read = 1'b1; cpu_address = 8'h20;
        gr = '0; g = 0; n_acc = 0; n_val = 0; bad_data = 0; drop_next = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            take_no_action_ocimem_a = 1'b0;
            if (drop_next) begin
                cpu_read  = 1'b0;
                drop_next = 1'b0;
            end
            if (ram_re && g < 4) begin
                gr[g] = !cpu_waitrequest;
                g++;
            end
            if (!cpu_waitrequest) begin
                n_acc++;
                if (i >= 20) drop_next = 1'b1;
            end
            if (cpu_readdatavalid) begin
                n_val++;
                if (cpu_readdata != 32'hC0C0C0C0) bad_data++;
            end
            if (!jtag_busy && i < 20) take_no_action_ocimem_a = 1'b1;
        end
        take_no_action_ocimem_a = 1'b0;
        wait_idle("alt_idle");
        check("alt_grants",   32'(gr), 32'b1010);
        check("alt_rdv_cnt",  32'(n_val), 32'(n_acc));
        check("alt_min_acc",  32'(n_acc >= 3), 32'd1);
        check("alt_rdata",    32'(bad_data), 32'd0);
        check("alt_no_ovf",   32'(jtag_ovf), 32'd0);

        // CPU write into the low region with and without debugack
        debugack = 1'b0;
`ifdef MASTER_CPU_OCIMEM_WP_EN
        cpu_wr(8'h05, 32'h55, "wp_blocked", 1'b0);
        check("wp_mem_kept", mem[8'h05], 32'h0);
        debugack = 1'b1;
        cpu_wr(8'h05, 32'h55, "wp_debug", 1'b1);
        check("wp_mem_written", mem[8'h05], 32'h55);
`else
        cpu_wr(8'h05, 32'h55, "nowp", 1'b1);
        check("nowp_mem", mem[8'h05], 32'h55);
`endif
        cpu_wr(8'h80, 32'hA5A5A5A5, "cpu_hi", 1'b1);
        check("cpu_hi_mem", mem[8'h80], 32'hA5A5A5A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/master_cpu_ocimem_arbiter.md
Name: master_cpu_ocimem_arbiter

Overview:
- Sysclk-domain controller for the debug module's on-chip memory (OCI RAM: 2^ADDR_W x 32, 1-cycle read latency).
- Decodes JTAG debug take_action/take_no_action strobes plus jdo into RAM reads and writes, with auto-incrementing address.
- Arbitrates those accesses against CPU-side Avalon slave accesses to the same RAM, and returns JTAG read data on MonDReg.

Parameters:
ADDR_W, 8, RAM word-address width (256 words)
WP_WORDS, 64, size in words of the low write-protected region (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
take_action_ocimem_a  in  1  JTAG strobe: load address; optional read
take_action_ocimem_b  in  1  JTAG strobe: write data at address, then increment address
take_no_action_ocimem_a  in  1  JTAG strobe: read at address, then increment address
jdo  in  38  JTAG data: addr = jdo[ADDR_W+16:17], rd flag = jdo[34], wdata = jdo[34:3]
debugack  in  1  CPU is in debug mode
cpu_read  in  1  Avalon read request
cpu_write  in  1  Avalon write request
cpu_address  in  ADDR_W  Avalon word address
cpu_writedata  in  32  Avalon write data
cpu_waitrequest  out  1  Avalon wait; low only in the cycle the request is accepted
cpu_readdata  out  32  read data
cpu_readdatavalid  out  1  one-cycle pulse when cpu_readdata is valid
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable
ram_rdata  in  32  RAM read data, valid the cycle after ram_re
MonDReg  out  32  last JTAG read data
jtag_busy  out  1  JTAG command pending or in progress
jtag_ovf  out  1  sticky: a JTAG strobe was dropped

Behaviour:
- Reset:
  - State goes to IDLE; all outputs 0 except cpu_waitrequest = 1.
  - jtag_addr = 0, jtag_pend = 0, last_cpu = 1.
  - ram_we/ram_re decode from state only, so reset deasserts them immediately, mid-access included.
- JTAG capture, on the edge after a strobe:
  - ocimem_a: jtag_addr <= jdo addr field. If jdo[34] = 1, pend a read.
  - ocimem_b: pend a write of jdo[34:3].
  - no_action_ocimem_a: pend a read.
- Strobe collisions:
  - More than one strobe in the same cycle: priority a > b > no_action.
  - Strobe while jtag_pend = 1 and the pending command is not consumed that cycle: strobe dropped, jtag_ovf <= 1.
  - jtag_ovf clears only on an accepted ocimem_a.
- FSM states: IDLE, JTAG_ACC, JTAG_RDW, CPU_ACC, CPU_RDW.
- IDLE arbitration:
  - If jtag_pend && (!cpu_req || last_cpu): go to JTAG_ACC, clear jtag_pend, last_cpu <= 0.
  - Else if cpu_req (= cpu_read | cpu_write): go to CPU_ACC, last_cpu <= 1.
  - Net effect: strict alternation under contention; JTAG wins the first tie.
- JTAG_ACC:
  - Drive ram_addr = jtag_addr, plus ram_we/ram_wdata or ram_re.
  - Writes: jtag_addr increments mod 2^ADDR_W, then go to IDLE.
  - Reads: go to JTAG_RDW.
- JTAG_RDW: MonDReg <= ram_rdata; post-read increment of jtag_addr; go to IDLE.
- A strobe accepted in the same cycle the pending command is consumed (the IDLE->JTAG_ACC edge) is legal. An ocimem_a address load there overrides that command's auto-increment.
- CPU_ACC:
  - cpu_waitrequest = 0 (combinational); ram driven from cpu_* signals.
  - Write: go to IDLE. Read: go to CPU_RDW.
- CPU_RDW: cpu_readdatavalid = 1, cpu_readdata = ram_rdata; go to IDLE.
- Latency, from strobe cycle T:
  - JTAG read: ram_re in T+2; MonDReg updated and visible in T+4.
  - JTAG write: ram_we in T+2.
  - CPU, uncontended: accepted the cycle after IDLE is seen.
- jtag_busy = jtag_pend | state in {JTAG_ACC, JTAG_RDW}.

Optional Feature:
- Macro MASTER_CPU_OCIMEM_WP_EN.
- Defined: a CPU write with cpu_address < WP_WORDS while debugack = 0 is accepted (waitrequest drops) but ram_we stays 0. JTAG writes are never blocked.
- Undefined: all CPU writes proceed; debugack is ignored, but the port stays present.

Decomposition:
- Shared package master_cpu_ocimem_pkg:
  - FSM state enum.
  - jdo field position constants (ADDR_LSB = 17, RD_BIT = 34, WDATA_MSB = 34, WDATA_LSB = 3).
- Sub-module master_cpu_ocimem_jtag_cmd: strobe decode, jtag_addr/jtag_pend/jtag_ovf registers, increment logic.
- FSM and muxing stay in the top module.

Test Plan:
- ocimem_a with addr = 0x10, rd = 1; RAM[0x10] = 0xDEADBEEF -> ram_re with ram_addr = 0x10 at T+2; MonDReg = 0xDEADBEEF at T+4; jtag_addr = 0x11.
- ocimem_a with addr = 0xFF, rd = 0, then three ocimem_b writes of 1, 2, 3 -> RAM[0xFF] = 1, RAM[0x00] = 2, RAM[0x01] = 3 (wrap).
- cpu_read held continuously plus back-to-back JTAG reads -> grants alternate JTAG, CPU, JTAG, CPU; no cpu_readdatavalid lost.
- Second strobe while jtag_pend = 1 and a CPU access is in progress -> jtag_ovf = 1, strobe discarded; next ocimem_a clears jtag_ovf.
- reset_n pulsed low during JTAG_ACC write -> ram_we falls asynchronously; all outputs return to reset values; RAM content unchanged after release.
- MASTER_CPU_OCIMEM_WP_EN defined, debugack = 0, CPU write 0x55 to 0x05 -> accepted, ram_we stays 0. Same write with debugack = 1 -> RAM[0x05] = 0x55.
